div_sequencer: RTL

- Multi-cycle iterative divide unit and its controlling FSM for the execute stage. Serves DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
- Divide opcodes are steered here instead of to the single-cycle ALU.
- The execute stage is stalled through a valid/ready handshake until the result returns with its destination tag.
- Corner cases follow the RISC-V M-extension results exactly.

---
 rtl/div_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for DIV/DIVU/REM/REMU and the
// 32-bit W forms. The execute stage hands over an op through a valid/ready
// handshake. The result comes back with its destination tag.
// Divide-by-zero and signed overflow follow the RISC-V M-extension results
// and skip the iterative loop.
module div_sequencer #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic             req_word,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy
);

   localparam int CNT_W = $clog2(XLEN);
   localparam int HI_W  = XLEN - 32;

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

   state_t             state_reg, state_next;
   logic [1:0]         op_reg;
   logic               word_reg;
   logic               q_neg_reg;
   logic               r_neg_reg;
   logic [XLEN-1:0]    divisor_reg;
   logic [XLEN-1:0]    rem_reg;
   logic [XLEN-1:0]    quo_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [XLEN-1:0]    resp_data_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic [TAG_W-1:0]   resp_tag_reg;

   // Request decode (only meaningful while IDLE)
   logic               accept;
   logic               is_signed;
   logic               a_sign, b_sign;
   logic [XLEN-1:0]    a_op, b_op;
   logic [XLEN-1:0]    a_abs_full, b_abs_full;
   logic [XLEN-1:0]    a_mag, b_mag;
   logic [XLEN-1:0]    a_sext;
   logic               div_zero, overflow, special;
   logic [XLEN-1:0]    special_data;

   // Iteration and fix-up datapath
   logic [XLEN:0]      rem_shift;
   logic [XLEN:0]      diff;
   logic               ge;
   logic [XLEN-1:0]    rem_step, quo_step;
   logic [XLEN-1:0]    q_mag, q_fix, r_fix, sel;
   logic [XLEN-1:0]    fix_data;

   assign req_ready  = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign resp_valid = (state_reg == DONE);
   assign resp_data  = resp_data_reg;
   assign resp_tag   = resp_tag_reg;

   // Operand preparation: widths, signs, magnitudes and corner-case results
   always_comb begin
      accept     = (state_reg == IDLE) && req_valid && !flush;
      is_signed  = !req_op[0];
      a_sign     = req_word ? req_a[31] : req_a[XLEN-1];
      b_sign     = req_word ? req_b[31] : req_b[XLEN-1];
      a_op       = req_word ? {{HI_W{1'b0}}, req_a[31:0]} : req_a;
      b_op       = req_word ? {{HI_W{1'b0}}, req_b[31:0]} : req_b;
      a_abs_full = (is_signed && a_sign) ? -a_op : a_op;
      b_abs_full = (is_signed && b_sign) ? -b_op : b_op;
      a_mag      = req_word ? {{HI_W{1'b0}}, a_abs_full[31:0]} : a_abs_full;
      b_mag      = req_word ? {{HI_W{1'b0}}, b_abs_full[31:0]} : b_abs_full;
      a_sext     = req_word ? {{HI_W{req_a[31]}}, req_a[31:0]} : req_a;
      div_zero   = (b_op == '0);
      overflow   = is_signed &&
                   (req_word ? (req_a[31:0] == 32'h8000_0000 && req_b[31:0] == 32'hFFFF_FFFF)
                             : (req_a == {1'b1, {(XLEN-1){1'b0}}} && (&req_b)));
      special    = div_zero || overflow;
      if (div_zero)
         special_data = req_op[1] ? a_sext : '1;
      else
         special_data = req_op[1] ? '0 : a_sext;
   end

   // One restoring step; the borrow of the trial subtraction decides the quotient bit
   always_comb begin
      rem_shift = {rem_reg, quo_reg[XLEN-1]};
      diff      = rem_shift - {1'b0, divisor_reg};
      ge        = !diff[XLEN];
      rem_step  = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quo_step  = {quo_reg[XLEN-2:0], ge};
   end

   // Sign correction, quotient/remainder select and W sign-extension
   always_comb begin
      q_mag    = word_reg ? {{HI_W{1'b0}}, quo_reg[31:0]} : quo_reg;
      q_fix    = q_neg_reg ? -q_mag : q_mag;
      r_fix    = r_neg_reg ? -rem_reg : rem_reg;
      sel      = op_reg[1] ? r_fix : q_fix;
      fix_data = word_reg ? {{HI_W{sel[31]}}, sel[31:0]} : sel;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = special ? DONE : BUSY;
         BUSY:    if (cnt_reg == '0) state_next = FIXUP;
         FIXUP:   state_next = DONE;
         DONE:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush)
         state_next = IDLE;
   end

   // Working registers: latch on accept, iterate in BUSY, publish in FIXUP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg        <= '0;
         word_reg      <= 1'b0;
         q_neg_reg     <= 1'b0;
         r_neg_reg     <= 1'b0;
         divisor_reg   <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         cnt_reg       <= '0;
         tag_reg       <= '0;
         resp_data_reg <= '0;
         resp_tag_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg      <= req_op;
                  word_reg    <= req_word;
                  tag_reg     <= req_tag;
                  q_neg_reg   <= is_signed && (a_sign ^ b_sign);
                  r_neg_reg   <= is_signed && a_sign;
                  divisor_reg <= b_mag;
                  rem_reg     <= '0;
                  // W dividends sit in the top half so 32 shifts consume them
                  quo_reg     <= req_word ? {a_mag[31:0], {HI_W{1'b0}}} : a_mag;
                  cnt_reg     <= req_word ? CNT_W'(31) : CNT_W'(XLEN - 1);
                  if (special) begin
                     resp_data_reg <= special_data;
                     resp_tag_reg  <= req_tag;
                  end
               end
            end
            BUSY: begin
               rem_reg <= rem_step;
               quo_reg <= quo_step;
               cnt_reg <= cnt_reg - 1'b1;
            end
            FIXUP: begin
               if (!flush) begin
                  resp_data_reg <= fix_data;
                  resp_tag_reg  <= tag_reg;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
